cpuif_host_bridge: RTL



---
 rtl/cpuif_bridge_pkg.sv | 18 +
 rtl/cpuif_rsp_fifo.sv | 59 +++++
 rtl/cpuif_host_bridge.sv | 133 +++++++++++++
 3 files changed

// File: rtl/cpuif_bridge_pkg.sv
// Shared types for the host-to-regblock bridge: the buffered response record
// and the byte-alignment mask helper.
package cpuif_bridge_pkg;

    // Widest data path the response record can carry; narrower buses use the low bits.
    localparam int RSP_DATA_MAX = 64;

    typedef struct packed {
        logic                    is_wr;
        logic                    err;
        logic [RSP_DATA_MAX-1:0] rdata;
    } rsp_t;

    function automatic logic [63:0] align_mask(input int data_width);
        return 64'((data_width / 8) - 1);
    endfunction

endpackage

// File: rtl/cpuif_rsp_fifo.sv
// Response buffer: first-word-fall-through FIFO with registered storage,
// non-power-of-two depth allowed, push and pop together legal when full.
module cpuif_rsp_fifo
    import cpuif_bridge_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          push,
    input  rsp_t          push_data,
    input  logic          pop,
    output rsp_t          head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    rsp_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cpuif_host_bridge.sv
// Host request/response bridge onto a regblock cpuif: zero-latency issue of
// aligned requests, credit-limited outstanding tracking, in-order responses.
module cpuif_host_bridge
    import cpuif_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                    clk,
    input  logic                    arst_n,
    input  logic                    s_req_valid,
    output logic                    s_req_ready,
    input  logic                    s_req_is_wr,
    input  logic [ADDR_WIDTH-1:0]   s_req_addr,
    input  logic [DATA_WIDTH-1:0]   s_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_req_wstrb,
    output logic                    s_rsp_valid,
    input  logic                    s_rsp_ready,
    output logic                    s_rsp_is_wr,
    output logic                    s_rsp_err,
    output logic [DATA_WIDTH-1:0]   s_rsp_rdata,
    output logic                    cpuif_req,
    output logic                    cpuif_req_is_wr,
    output logic [ADDR_WIDTH-1:0]   cpuif_addr,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_data,
    output logic [DATA_WIDTH-1:0]   cpuif_wr_biten,
    input  logic                    cpuif_req_stall_wr,
    input  logic                    cpuif_req_stall_rd,
    input  logic                    cpuif_rd_ack,
    input  logic                    cpuif_rd_err,
    input  logic [DATA_WIDTH-1:0]   cpuif_rd_data,
    input  logic                    cpuif_wr_ack,
    input  logic                    cpuif_wr_err
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int SW = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'(align_mask(DATA_WIDTH));

    logic [CW-1:0] outstanding;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credits;
    logic          has_credit;
    logic          aligned;
    logic          stalled;
    logic          accept;
    logic          issue;
    logic          misaligned_push;
    logic          ack_any;
    logic          fifo_push;
    logic          fifo_full;
    logic          fifo_empty;
    rsp_t          push_data;
    rsp_t          head;
    logic          head_rdata_unused;

    assign credits    = {1'b0, outstanding} + {1'b0, fifo_count};
    assign has_credit = credits < (CW + 1)'(MAX_OUTSTANDING);
    assign aligned    = ((s_req_addr & ALIGN_MASK) == '0);
    assign stalled    = s_req_is_wr ? cpuif_req_stall_wr : cpuif_req_stall_rd;

    // Misaligned requests are answered locally, so they wait for the pipe to
    // drain to keep their error response in order behind real completions.
    assign s_req_ready = arst_n && has_credit && !stalled
                         && (aligned || (outstanding == '0 && !fifo_full));

    assign accept          = s_req_valid && s_req_ready;
    assign issue           = accept && aligned;
    assign misaligned_push = accept && !aligned;

    assign cpuif_req       = issue;
    assign cpuif_req_is_wr = arst_n && s_req_is_wr;
    assign cpuif_addr      = arst_n ? s_req_addr  : '0;
    assign cpuif_wr_data   = arst_n ? s_req_wdata : '0;

    always_comb begin
        cpuif_wr_biten = '0;
        for (int i = 0; i < SW; i++) begin
            cpuif_wr_biten[8*i +: 8] = {8{s_req_wstrb[i] & arst_n}};
        end
    end

    assign ack_any   = (cpuif_rd_ack || cpuif_wr_ack) && (outstanding != '0);
    assign fifo_push = ack_any || misaligned_push;

    always_comb begin
        push_data = '0;
        if (ack_any) begin
            push_data.is_wr = cpuif_wr_ack;
            push_data.err   = cpuif_wr_ack ? cpuif_wr_err : cpuif_rd_err;
            if (!cpuif_wr_ack) begin
                push_data.rdata[DATA_WIDTH-1:0] = cpuif_rd_data;
            end
        end else if (misaligned_push) begin
            push_data.is_wr = s_req_is_wr;
            push_data.err   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            outstanding <= '0;
        end else begin
            case ({issue, ack_any})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    cpuif_rsp_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_rsp_fifo (
        .clk       (clk),
        .arst_n    (arst_n),
        .push      (fifo_push),
        .push_data (push_data),
        .pop       (s_rsp_ready),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign s_rsp_valid       = !fifo_empty;
    assign s_rsp_is_wr       = head.is_wr;
    assign s_rsp_err         = head.err;
    assign s_rsp_rdata       = head.rdata[DATA_WIDTH-1:0];
    assign head_rdata_unused = ^head.rdata;

endmodule
